// File: rtl/timer_pkg.sv
// timer_pkg: register map, control/status bit positions and write-strobe bundle for the APB timer
package timer_pkg;
  localparam logic [7:0] TDR_ADDR  = 8'h00;
  localparam logic [7:0] TCR_ADDR  = 8'h01;
  localparam logic [7:0] TSR_ADDR  = 8'h02;
  localparam logic [7:0] TCNT_ADDR = 8'h03;
  localparam int TCR_LOAD = 7;
  localparam int TCR_DOWN = 5;
  localparam int TCR_EN   = 4;
  localparam logic [7:0] TCR_MASK = 8'hB3;
  localparam int TSR_OVF = 0;
  localparam int TSR_URF = 1;
  typedef struct packed {
    logic tdr;
    logic tcr;
    logic tsr;
  } wr_t;
endpackage

// File: rtl/timer_if.sv
// timer_if: APB signal bundle between the SoC master and the timer slave
interface timer_if #(parameter int ADDR_WIDTH = 8, parameter int DATA_WIDTH = 8);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/timer_apb.sv
// timer_apb: zero-wait APB decode, read mux, error flag and register write strobes
module timer_apb import timer_pkg::*; #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  timer_if.slave               bus,
  input  logic [DATA_WIDTH-1:0] tdr,
  input  logic [DATA_WIDTH-1:0] tcr,
  input  logic [DATA_WIDTH-1:0] tsr,
  input  logic [DATA_WIDTH-1:0] tcnt,
  output wr_t                   wr
);
  logic PREADY;
  logic hit;
  logic wr_en;
  assign PREADY = bus.PSEL & bus.PENABLE;
  assign hit = bus.PADDR <= ADDR_WIDTH'(TCNT_ADDR);
  // commits are gated by PREADY so a stalled access phase writes nothing
  assign wr_en = PREADY & bus.PWRITE & hit;
  assign wr.tdr = wr_en & (bus.PADDR == ADDR_WIDTH'(TDR_ADDR));
  assign wr.tcr = wr_en & (bus.PADDR == ADDR_WIDTH'(TCR_ADDR));
  assign wr.tsr = wr_en & (bus.PADDR == ADDR_WIDTH'(TSR_ADDR));
  assign bus.PREADY = PREADY;
  assign bus.PSLVERR = bus.PSEL & bus.PENABLE & ~hit;
  always_comb begin
    bus.PRDATA = '0;
    if (bus.PSEL & ~bus.PWRITE)
      bus.PRDATA = (bus.PADDR == ADDR_WIDTH'(TDR_ADDR)) ? tdr :
                   (bus.PADDR == ADDR_WIDTH'(TCR_ADDR)) ? tcr :
                   (bus.PADDR == ADDR_WIDTH'(TSR_ADDR)) ? tsr :
                   (bus.PADDR == ADDR_WIDTH'(TCNT_ADDR)) ? tcnt : '0;
  end
endmodule

// File: rtl/timer_counter.sv
// timer_counter: TDR/TCR/TSR registers, load/tick edge detection and the up/down counter
module timer_counter import timer_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET_n,
  input  wr_t                   wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  Clock_counter,
  output logic [DATA_WIDTH-1:0] tdr,
  output logic [DATA_WIDTH-1:0] tcr,
  output logic [DATA_WIDTH-1:0] tsr,
  output logic [DATA_WIDTH-1:0] tcnt
);
  logic cc_q, load_q, tick, load, step, down, ovf_set, urf_set;
  logic [DATA_WIDTH-1:0] tsr_clr, tsr_set;
  assign tick = Clock_counter & ~cc_q;
  assign load = tcr[TCR_LOAD] & ~load_q;
  assign down = tcr[TCR_DOWN];
  assign step = tcr[TCR_EN] & tick & ~load;
  assign ovf_set = step & ~down & (tcnt == '1);
  assign urf_set = step & down & (tcnt == '0);
  assign tsr_clr = wr.tsr ? wdata : '0;
  // a hardware set lands after the clear so it wins in the same cycle
  assign tsr_set = DATA_WIDTH'({urf_set, ovf_set});
  always_ff @(posedge PCLK or posedge PRESET_n)
    if (PRESET_n) begin
      tdr <= '0;
      tcr <= '0;
      tsr <= '0;
      tcnt <= '0;
      cc_q <= 1'b0;
      load_q <= 1'b0;
    end else begin
      cc_q <= Clock_counter;
      load_q <= tcr[TCR_LOAD];
      if (wr.tdr) tdr <= wdata;
      if (wr.tcr) tcr <= wdata & DATA_WIDTH'(TCR_MASK);
      tsr <= (tsr & ~tsr_clr) | tsr_set;
      tcnt <= load ? tdr : step ? (down ? tcnt - 1'b1 : tcnt + 1'b1) : tcnt;
    end
endmodule

// File: rtl/timer_selclk.sv
// timer_selclk: free-running prescaler; Clock_counter is PCLK divided by 2/4/8/16
module timer_selclk (
  input  logic       PCLK,
  input  logic       PRESET_n,
  input  logic [1:0] cks,
  output logic       Clock_counter
);
  logic [3:0] div;
  always_ff @(posedge PCLK or posedge PRESET_n)
    if (PRESET_n) div <= '0;
    else div <= div + 4'd1;
  assign Clock_counter = div[cks];
endmodule

// File: rtl/timer_top.sv
// timer_top: 8-bit programmable up/down timer behind an APB slave port
module timer_top import timer_pkg::*; #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic   PCLK,
  input  logic   PRESET_n,
  timer_if.slave apb,
  output logic   TMR_OVF,
  output logic   TMR_URF
);
  wr_t wr;
  logic Clock_counter;
  logic [DATA_WIDTH-1:0] tdr, tcr, tsr, tcnt;
  timer_apb #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_apb (
    .bus(apb), .tdr(tdr), .tcr(tcr), .tsr(tsr), .tcnt(tcnt), .wr(wr)
  );
  timer_selclk u_selclk (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .cks(tcr[1:0]), .Clock_counter(Clock_counter)
  );
  timer_counter #(.DATA_WIDTH(DATA_WIDTH)) u_counter (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .wr(wr), .wdata(apb.PWDATA),
    .Clock_counter(Clock_counter), .tdr(tdr), .tcr(tcr), .tsr(tsr), .tcnt(tcnt)
  );
  assign TMR_OVF = tsr[TSR_OVF];
  assign TMR_URF = tsr[TSR_URF];
endmodule

// File: tb/tb_timer_top.sv
// tb_timer_top: directed self-checking bench for the APB timer
module tb_timer_top;
  logic PCLK = 1'b0;
  logic PRESET_n = 1'b1;
  logic TMR_OVF, TMR_URF;
  int errors = 0;
  int checks = 0;
  logic [7:0] rd;
  logic err;
  logic [7:0] addrs [20] = '{8'h00, 8'h05, 8'h03, 8'hFF, 8'h01, 8'h80, 8'h04, 8'h02, 8'h10, 8'h7F,
                             8'h03, 8'h00, 8'hC4, 8'h21, 8'h02, 8'h08, 8'h01, 8'hFE, 8'h40, 8'h06};
  timer_if bus ();
  timer_top dut (.PCLK(PCLK), .PRESET_n(PRESET_n), .apb(bus), .TMR_OVF(TMR_OVF), .TMR_URF(TMR_URF));
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d, input int stall,
                      output logic [7:0] r, output logic e);
    logic rdy = 1'b0;
    @(posedge PCLK) #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = w; bus.PADDR = a; bus.PWDATA = d;
    @(posedge PCLK) #1;
    bus.PENABLE = 1'b1;
    if (stall > 0) begin
      force dut.u_apb.PREADY = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(negedge PCLK);
        chk("stall_pready", {7'd0, bus.PREADY}, 8'h00);
        if (w && a == 8'h00) chk("stall_no_commit", dut.u_counter.tdr, 8'h55);
        @(posedge PCLK) #1;
      end
      release dut.u_apb.PREADY;
    end
    for (int i = 0; i < 16 && !rdy; i++) begin
      @(negedge PCLK);
      rdy = bus.PREADY;
    end
    if (!rdy) chk("pready_timeout", {7'd0, rdy}, 8'h01);
    r = bus.PRDATA;
    e = bus.PSLVERR;
    @(posedge PCLK) #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    logic e;
    xfer(1'b1, a, d, 0, r, e);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] r;
    logic e;
    xfer(1'b0, a, 8'h00, 0, r, e);
    chk(tag, r, exp);
  endtask

  task automatic do_reset();
    PRESET_n = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESET_n = 1'b0;
  endtask

  task automatic edge_cc();
    force dut.u_selclk.Clock_counter = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 force dut.u_selclk.Clock_counter = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
  endtask

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    do_reset();
    @(negedge PCLK);
    chk("rst_prdata", bus.PRDATA, 8'h00);
    chk("rst_pready", {7'd0, bus.PREADY}, 8'h00);
    chk("rst_pslverr", {7'd0, bus.PSLVERR}, 8'h00);
    chk("rst_ovf", {7'd0, TMR_OVF}, 8'h00);
    chk("rst_urf", {7'd0, TMR_URF}, 8'h00);
    rd_chk("rst_tdr", 8'h00, 8'h00);
    rd_chk("rst_tcr", 8'h01, 8'h00);
    rd_chk("rst_tcnt", 8'h03, 8'h00);
    for (int i = 0; i < 20; i++) begin
      xfer(1'b1, addrs[i], addrs[i] ^ 8'h5A, 0, rd, err);
      chk($sformatf("pslverr_%02h", addrs[i]), {7'd0, err}, {7'd0, addrs[i] > 8'h03});
    end
    xfer(1'b0, 8'h10, 8'h00, 0, rd, err);
    chk("bad_read_err", {7'd0, err}, 8'h01);
    chk("bad_read_data", rd, 8'h00);
    do_reset();
    force dut.u_selclk.Clock_counter = 1'b0;
    wr(8'h00, 8'hA5);
    rd_chk("tdr_rw", 8'h00, 8'hA5);
    wr(8'h01, 8'hFF);
    rd_chk("tcr_mask", 8'h01, 8'hB3);
    wr(8'h02, 8'hFF);
    rd_chk("tsr_w1c", 8'h02, 8'h00);
    wr(8'h03, 8'h12);
    rd_chk("tcnt_ro", 8'h03, 8'hA5);
    wr(8'h00, 8'h3C);
    wr(8'h01, 8'h00);
    wr(8'h01, 8'h80);
    wr(8'h01, 8'h00);
    rd_chk("load_tcnt", 8'h03, 8'h3C);
    wr(8'h00, 8'hFF);
    wr(8'h01, 8'h80);
    wr(8'h01, 8'h10);
    rd_chk("up_loaded", 8'h03, 8'hFF);
    edge_cc();
    chk("up_wrap_ovf", {7'd0, TMR_OVF}, 8'h01);
    edge_cc();
    rd_chk("up_tcnt", 8'h03, 8'h01);
    chk("up_ovf_held", {7'd0, TMR_OVF}, 8'h01);
    chk("up_urf", {7'd0, TMR_URF}, 8'h00);
    wr(8'h02, 8'h03);
    wr(8'h01, 8'h00);
    wr(8'h00, 8'h00);
    wr(8'h01, 8'h80);
    wr(8'h01, 8'h30);
    edge_cc();
    edge_cc();
    rd_chk("dn_tcnt", 8'h03, 8'hFE);
    chk("dn_urf", {7'd0, TMR_URF}, 8'h01);
    chk("dn_ovf", {7'd0, TMR_OVF}, 8'h00);
    rd_chk("dn_tsr", 8'h02, 8'h02);
    wr(8'h02, 8'h03);
    chk("clr_urf", {7'd0, TMR_URF}, 8'h00);
    chk("clr_ovf", {7'd0, TMR_OVF}, 8'h00);
    wr(8'h01, 8'h00);
    wr(8'h00, 8'h55);
    xfer(1'b1, 8'h00, 8'h77, 3, rd, err);
    rd_chk("stall_wr_done", 8'h00, 8'h77);
    xfer(1'b0, 8'h00, 8'h00, 3, rd, err);
    chk("stall_rd_data", rd, 8'h77);
    chk("stall_rd_err", {7'd0, err}, 8'h00);
    #3 PRESET_n = 1'b1;
    #1 chk("async_rst_tdr", dut.u_counter.tdr, 8'h00);
    PRESET_n = 1'b0;
    rd_chk("post_rst_tdr", 8'h00, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
